// File: rtl/sram_sim_pkg.sv
// ============================================================================
// sram_sim_pkg : shared widths and lane helper for the SRAM simulation model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package sram_sim_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 8;
    localparam int DEFAULT_WMASK_WIDTH = 4;

    function automatic int lane_width(input int data_width, input int wmask_width);
        return data_width / wmask_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_sim_array.sv
// ============================================================================
// sram_sim_array : storage array with masked synchronous write, registered read
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sram_sim_array
    import sram_sim_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEFAULT_WMASK_WIDTH,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout
);

    localparam int LANE  = lane_width(DATA_WIDTH, WMASK_WIDTH);
    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    // The array is deliberately outside reset; contents start at zero.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign in_range = (32'(addr) < 32'(RAM_DEPTH));
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset && we && in_range) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask[i]) begin
                    mem[idx][i*LANE +: LANE] <= din[i*LANE +: LANE];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (!we) begin
            dout <= in_range ? mem[idx] : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_sim_model.sv
// ============================================================================
// sram_sim_model : single-port SRAM model with registered input stage
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sram_sim_model
    import sram_sim_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEFAULT_WMASK_WIDTH,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout
);

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_lane_split
        $error("sram_sim_model: DATA_WIDTH must be divisible by WMASK_WIDTH");
    end

    if (RAM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_sim_model: RAM_DEPTH exceeds the address space");
    end

    logic                   we_reg;
    logic [WMASK_WIDTH-1:0] wmask_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0]  din_reg;

    // Reset clears we_reg, so the first operation after release is a read of 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_reg    <= 1'b0;
            wmask_reg <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            we_reg    <= we;
            wmask_reg <= wmask;
            addr_reg  <= addr;
            din_reg   <= din;
        end
    end

    sram_sim_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WMASK_WIDTH (WMASK_WIDTH),
        .RAM_DEPTH   (RAM_DEPTH)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (we_reg),
        .wmask (wmask_reg),
        .addr  (addr_reg),
        .din   (din_reg),
        .dout  (dout)
    );

endmodule

`default_nettype wire

// File: tb/tb_sram_sim_model.sv
// ============================================================================
// tb_sram_sim_model : directed self-checking bench for sram_sim_model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_sram_sim_model;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [3:0]  wmask = 4'b0000;
    logic [7:0]  addr  = 8'h00;
    logic [31:0] din   = 32'h0;
    logic [31:0] dout;

    int checks = 0;
    int passed = 0;

    sram_sim_model #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (8),
        .WMASK_WIDTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .wmask (wmask),
        .addr  (addr),
        .din   (din),
        .dout  (dout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    // Called at a falling edge; inputs are held for two rising edges.
    task automatic do_op(input logic w, input logic [3:0] m,
                         input logic [7:0] a, input logic [31:0] d);
        we    = w;
        wmask = m;
        addr  = a;
        din   = d;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic read_check(input string name, input logic [7:0] a,
                              input logic [31:0] exp);
        do_op(1'b0, 4'b0000, a, 32'h0);
        checks++;
        if (dout !== exp)
            $display("FAIL %s got=%h exp=%h", name, dout, exp);
        else
            passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (dout !== 32'h0) $display("FAIL reset_dout got=%h exp=%h", dout, 32'h0);
        else passed++;
        reset = 1'b0;
        read_check("read_unwritten_5", 8'd5, 32'h0);
    endtask

    task automatic test_full_write;
        do_op(1'b1, 4'b1111, 8'd3, 32'hDEADBEEF);
        read_check("full_write_3", 8'd3, 32'hDEADBEEF);
    endtask

    task automatic test_masked_write;
        do_op(1'b1, 4'b0101, 8'd3, 32'h11223344);
        read_check("masked_write_3", 8'd3, 32'hDE22BE44);
    endtask

    task automatic test_boundary_addr;
        do_op(1'b1, 4'b1111, 8'd255, 32'hA5A5A5A5);
        do_op(1'b1, 4'b1111, 8'd0,   32'h5A5A5A5A);
        read_check("addr_255", 8'd255, 32'hA5A5A5A5);
        read_check("addr_0",   8'd0,   32'h5A5A5A5A);
    endtask

    task automatic test_dout_hold;
        read_check("hold_pre_read", 8'd3, 32'hDE22BE44);
        we    = 1'b1;
        wmask = 4'b1111;
        addr  = 8'd7;
        din   = 32'h01234567;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (dout !== 32'hDE22BE44)
                $display("FAIL hold_during_write[%0d] got=%h exp=%h", k, dout, 32'hDE22BE44);
            else
                passed++;
        end
        read_check("addr_7_written", 8'd7, 32'h01234567);
    endtask

    task automatic test_reset_mid_write;
        we    = 1'b1;
        wmask = 4'b1111;
        addr  = 8'd9;
        din   = 32'hFFFFFFFF;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dout !== 32'h0) $display("FAIL reset_async_dout got=%h exp=%h", dout, 32'h0);
        else passed++;
        @(negedge clock);
        we = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (dout !== 32'h0) $display("FAIL reset_held_dout got=%h exp=%h", dout, 32'h0);
        else passed++;
        reset = 1'b0;
        read_check("lost_write_9", 8'd9, 32'h0);
        read_check("survives_reset_3", 8'd3, 32'hDE22BE44);
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_masked_write();
        test_boundary_addr();
        test_dout_hold();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_sim_model.md
# sram_sim_model

Behavioural single-port SRAM with a registered input stage, used as the DUT for SRAM energy characterization. Per cycle, one masked write or one read is captured on one clock edge and performed on the next. Read data is registered and holds until the next read completes. The module is named `sram_sim_model`, and the characterization bench instantiates it with the parameter and port names below.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width in bits.
- `ADDR_WIDTH`, default 8: address width in bits.
- `WMASK_WIDTH`, default 4: number of write-mask lanes. `DATA_WIDTH` must be divisible by `WMASK_WIDTH`. Lane i covers bits [(i+1)*L-1 : i*L], where L = `DATA_WIDTH`/`WMASK_WIDTH`.
- `RAM_DEPTH`, default 1<<`ADDR_WIDTH`: number of words. Must be ≤ 2^`ADDR_WIDTH`.

Ports:
- `clock`, input, 1 bit: single clock; all state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `we`, input, 1 bit: 1 = write, 0 = read.
- `wmask`, input, `WMASK_WIDTH` bits: per-lane write enable; ignored on reads.
- `addr`, input, `ADDR_WIDTH` bits: word address.
- `din`, input, `DATA_WIDTH` bits: write data.
- `dout`, output, `DATA_WIDTH` bits: registered read data.

## Operation
- **Stage 1 (input capture):** every rising edge registers `we`, `wmask`, `addr` and `din` into `we_reg`, `wmask_reg`, `addr_reg` and `din_reg`. There is no enable; a request is issued every cycle.
- **Stage 2, write (`we_reg`=1):**
  - `mem[addr_reg]` lanes with `wmask_reg[i]`=1 take `din_reg`; other lanes keep their old value.
  - `dout` holds its value.
- **Stage 2, read (`we_reg`=0):** `dout` ← `mem[addr_reg]`.
- **Out of range (`addr_reg` ≥ `RAM_DEPTH`):** writes are dropped; reads load `dout` with 0.
- **Initial contents:** the array starts at all-zero (simulation initialisation). Reset never alters the array.
- **Reset asserted, asynchronously:**
  - `we_reg`, `wmask_reg`, `addr_reg`, `din_reg` go to 0.
  - `dout` goes to 0.
  - While reset is held, no stage-2 write occurs.
  - Because `we_reg` is 0 out of reset, the first stage-2 operation after release is a read of address 0. It is harmless.
- **Reset mid-operation:** a request captured but not yet performed is lost. A write already committed stays in the array.

## Timing
- **Write latency:** inputs sampled at edge N; the array is updated at edge N+1.
- **Read latency:** inputs sampled at edge N; `dout` is valid after edge N+1 and stable by the following falling edge. It holds until the next stage-2 read.
- **Throughput:** the design is fully pipelined, one operation per cycle.
- **Write followed by read of the same address:**
  - Write sampled at N (committed at N+1), read sampled at N+1 (performed at N+2).
  - The read returns the new data; no bypass logic is needed.
- **Held inputs:** inputs held for 2 cycles (the bench's protocol) repeat the operation.
  - A repeated write of identical data/mask is idempotent.
  - A repeated read is harmless.

## Structure
- A shared package `sram_sim_pkg` holds:
  - the default width constants;
  - a `lane_width` function (`DATA_WIDTH`/`WMASK_WIDTH`).
- One natural sub-module, `sram_sim_array`: the storage array with a synchronous masked write and a registered read port, depth `RAM_DEPTH`.
- The top level contains:
  - the stage-1 input registers;
  - the reset logic;
  - the parameter checks, as elaboration-time assertions on divisibility and depth.

## Test plan
Parameters for all scenarios: 32/8/4 (`DATA_WIDTH`/`ADDR_WIDTH`/`WMASK_WIDTH`); each operation holds inputs for 2 cycles; `dout` is checked at the falling edge.
1. Reset pulse → `dout`=0. Read addr 5 afterwards → 0 (array not written).
2. Write 0xDEADBEEF to addr 3, mask 4'b1111; read addr 3 → 0xDEADBEEF.
3. Then write 0x11223344 to addr 3, mask 4'b0101; read addr 3 → 0xDE22BE44.
4. Write 0xA5A5A5A5 to addr 255, then 0x5A5A5A5A to addr 0. Read 255 → 0xA5A5A5A5; read 0 → 0x5A5A5A5A.
5. Read addr 3 (→ 0xDE22BE44), then write addr 7; `dout` stays 0xDE22BE44 through the write cycles.
6. Assert reset mid-write (after edge N, before N+1) to addr 9 with 0xFFFFFFFF. After release, read addr 9 → 0, and `dout` was 0 during reset.
